spu_rx_ctl: RTL and testbench

//  Receive-side packet controller; it is the counterpart of the SPU send controller. It accepts one head

---
 rtl/spu_rx_ctl.sv | 153 +++++++++++++++
 tb/tb_spu_rx_ctl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/spu_rx_ctl.sv
`default_nettype none
// ============================================================================
// Module   : spu_rx_ctl
// Purpose  : Receive-side SPU packet controller. Takes a head flit plus LEN
//            data flits from the NoC and writes them to consecutive SRAM words.
// Revision : 1.0 - initial release
// ============================================================================
module spu_rx_ctl #(
  parameter int DATA_W     = 128,
  parameter int LEN_W      = 8,
  parameter int ADDR_W     = 10,
  parameter int FLT_TO_DLY = 2000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              id_vld,
  output logic              id_rdy,
  input  logic              id_head,
  input  logic [DATA_W-1:0] id_data,
  output logic              sram_wr_en,
  output logic [ADDR_W-1:0] sram_wr_addr,
  output logic [DATA_W-1:0] sram_wr_data,
  input  logic              sram_wr_rdy,
  input  logic              retire_keep,
  output logic              pkt_done,
  output logic [LEN_W-1:0]  pkt_len,
  output logic              data_flt_timeout,
  output logic              miss_head_flt,
  output logic              len_error
);

  localparam int C_TICK_W = $clog2(FLT_TO_DLY + 2);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_RDF   = 4'b0010,
    ST_DONE  = 4'b0100,
    ST_ERROR = 4'b1000
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [LEN_W-1:0]    rem_cnt_q, rem_cnt_d;
  logic [LEN_W-1:0]    pkt_len_q, pkt_len_d;
  logic [C_TICK_W-1:0] ticks_q, ticks_d;
  logic                to_q, to_d;
  logic                miss_q, miss_d;
  logic                len_err_q, len_err_d;

  logic [LEN_W-1:0]    w_hd_len;
  logic [ADDR_W-1:0]   w_hd_base;
  logic                w_wr;

  assign w_hd_len  = id_data[LEN_W-1:0];
  assign w_hd_base = id_data[LEN_W+ADDR_W-1:LEN_W];

  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    rem_cnt_d  = rem_cnt_q;
    pkt_len_d  = pkt_len_q;
    ticks_d    = '0;
    to_d       = 1'b0;
    miss_d     = 1'b0;
    len_err_d  = 1'b0;
    id_rdy     = 1'b0;
    w_wr       = 1'b0;
    pkt_done   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        id_rdy = 1'b1;
        if (id_vld) begin
          if (!id_head) begin
            state_d = ST_ERROR;
            miss_d  = 1'b1;
          end else if (w_hd_len == '0) begin
            state_d   = ST_ERROR;
            len_err_d = 1'b1;
          end else begin
            state_d   = ST_RDF;
            wr_addr_d = w_hd_base;
            rem_cnt_d = w_hd_len;
            pkt_len_d = w_hd_len;
          end
        end
      end
      ST_RDF: begin
        id_rdy = sram_wr_rdy;
        w_wr   = id_vld & sram_wr_rdy & ~id_head;
        // Priority: write, then stray head, then stall timeout.
        if (w_wr) begin
          wr_addr_d = wr_addr_q + ADDR_W'(1);
          rem_cnt_d = rem_cnt_q - LEN_W'(1);
          if (rem_cnt_q == LEN_W'(1)) state_d = ST_DONE;
        end else if (id_vld & id_head & sram_wr_rdy) begin
          state_d   = ST_ERROR;
          len_err_d = 1'b1;
        end else if (ticks_q >= C_TICK_W'(FLT_TO_DLY)) begin
          state_d = ST_ERROR;
          to_d    = 1'b1;
        end else begin
          ticks_d = ticks_q + C_TICK_W'(1);
        end
      end
      ST_DONE: begin
        pkt_done = 1'b1;
        state_d  = ST_IDLE;
      end
      ST_ERROR: begin
        if (retire_keep) begin
          to_d      = to_q;
          miss_d    = miss_q;
          len_err_d = len_err_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      wr_addr_q <= '0;
      rem_cnt_q <= '0;
      pkt_len_q <= '0;
      ticks_q   <= '0;
      to_q      <= 1'b0;
      miss_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      rem_cnt_q <= rem_cnt_d;
      pkt_len_q <= pkt_len_d;
      ticks_q   <= ticks_d;
      to_q      <= to_d;
      miss_q    <= miss_d;
      len_err_q <= len_err_d;
    end
  end

  assign sram_wr_en       = w_wr;
  assign sram_wr_addr     = wr_addr_q;
  assign sram_wr_data     = id_data;
  assign pkt_len          = pkt_len_q;
  assign data_flt_timeout = to_q;
  assign miss_head_flt    = miss_q;
  assign len_error        = len_err_q;

endmodule
`default_nettype wire

// File: tb/tb_spu_rx_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spu_rx_ctl
// Purpose  : Directed self-checking bench for spu_rx_ctl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spu_rx_ctl;

  localparam int DW = 128;
  localparam int LW = 8;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          id_vld = 1'b0;
  logic          id_rdy;
  logic          id_head = 1'b0;
  logic [DW-1:0] id_data = '0;
  logic          sram_wr_en;
  logic [AW-1:0] sram_wr_addr;
  logic [DW-1:0] sram_wr_data;
  logic          sram_wr_rdy = 1'b1;
  logic          retire_keep = 1'b0;
  logic          pkt_done;
  logic [LW-1:0] pkt_len;
  logic          data_flt_timeout;
  logic          miss_head_flt;
  logic          len_error;

  int n_total = 0;
  int n_bad   = 0;

  logic [AW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];

  spu_rx_ctl #(.DATA_W(DW), .LEN_W(LW), .ADDR_W(AW), .FLT_TO_DLY(2000)) u_dut (
    .clk(clk), .rstn(rstn), .id_vld(id_vld), .id_rdy(id_rdy), .id_head(id_head),
    .id_data(id_data), .sram_wr_en(sram_wr_en), .sram_wr_addr(sram_wr_addr),
    .sram_wr_data(sram_wr_data), .sram_wr_rdy(sram_wr_rdy), .retire_keep(retire_keep),
    .pkt_done(pkt_done), .pkt_len(pkt_len), .data_flt_timeout(data_flt_timeout),
    .miss_head_flt(miss_head_flt), .len_error(len_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_wr_en) begin
      wa_q.push_back(sram_wr_addr);
      wd_q.push_back(sram_wr_data);
    end
  end

  task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] head_word(input logic [AW-1:0] base, input logic [LW-1:0] len);
    logic [DW-1:0] w;
    w          = '0;
    w[127:120] = 8'hA5;
    w[LW-1:0]  = len;
    w[LW+AW-1:LW] = base;
    return w;
  endfunction

  // Offer one flit and wait (bounded) for it to be accepted.
  task automatic xfer(input string tag, input logic hd, input logic [DW-1:0] d);
    bit done;
    done    = 1'b0;
    id_vld  = 1'b1;
    id_head = hd;
    id_data = d;
    for (int i = 0; i < 50 && !done; i++) begin
      #1;
      if (id_rdy) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) check_val({tag, "_accept"}, id_rdy, 1'b1);
    id_vld  = 1'b0;
    id_head = 1'b0;
    #1;
  endtask

  task automatic check_log(input string tag, input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
    check_val({tag, "_addr"}, (idx < wa_q.size()) ? DW'(wa_q[idx]) : {DW{1'bx}}, DW'(a));
    check_val({tag, "_data"}, (idx < wd_q.size()) ? wd_q[idx] : {DW{1'bx}}, d);
  endtask

  initial begin
    // 1: reset state
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    check_val("rst_rdy", id_rdy, 1'b1);
    check_val("rst_wr", sram_wr_en, 1'b0);
    check_val("rst_done", pkt_done, 1'b0);
    check_val("rst_len", pkt_len, 8'd0);
    check_val("rst_flags", {data_flt_timeout, miss_head_flt, len_error}, 3'b000);

    // 2: LEN=4 with address wrap
    wa_q.delete(); wd_q.delete();
    xfer("t2_head", 1'b1, head_word(10'h3FE, 8'd4));
    for (int i = 0; i < 4; i++) xfer("t2_dat", 1'b0, 128'hD000 + 128'(i));
    check_val("t2_done", pkt_done, 1'b1);
    check_val("t2_len", pkt_len, 8'd4);
    check_val("t2_rdy_done", id_rdy, 1'b0);
    tick();
    check_val("t2_done_off", pkt_done, 1'b0);
    check_val("t2_idle_rdy", id_rdy, 1'b1);
    check_val("t2_nwr", wa_q.size(), 4);
    check_log("t2_w0", 0, 10'h3FE, 128'hD000);
    check_log("t2_w1", 1, 10'h3FF, 128'hD001);
    check_log("t2_w2", 2, 10'h000, 128'hD002);
    check_log("t2_w3", 3, 10'h001, 128'hD003);

    // 3: SRAM back-pressure
    wa_q.delete(); wd_q.delete();
    xfer("t3_head", 1'b1, head_word(10'h100, 8'd3));
    xfer("t3_d0", 1'b0, 128'hE0);
    sram_wr_rdy = 1'b0;
    id_vld = 1'b1; id_data = 128'hE1;
    #1;
    for (int i = 0; i < 5; i++) begin
      check_val("t3_stall_rdy", id_rdy, 1'b0);
      check_val("t3_stall_wr", sram_wr_en, 1'b0);
      tick();
    end
    sram_wr_rdy = 1'b1;
    xfer("t3_d1", 1'b0, 128'hE1);
    xfer("t3_d2", 1'b0, 128'hE2);
    check_val("t3_done", pkt_done, 1'b1);
    check_val("t3_len", pkt_len, 8'd3);
    check_val("t3_flags", {data_flt_timeout, miss_head_flt, len_error}, 3'b000);
    tick();
    check_val("t3_nwr", wa_q.size(), 3);
    check_log("t3_w0", 0, 10'h100, 128'hE0);
    check_log("t3_w1", 1, 10'h101, 128'hE1);
    check_log("t3_w2", 2, 10'h102, 128'hE2);

    // 4: stall timeout with retire_keep hold
    wa_q.delete(); wd_q.delete();
    xfer("t4_head", 1'b1, head_word(10'h020, 8'd2));
    repeat (2000) tick();
    check_val("t4_pre_rdy", id_rdy, 1'b1);
    check_val("t4_pre_to", data_flt_timeout, 1'b0);
    retire_keep = 1'b1;
    tick();
    check_val("t4_to", data_flt_timeout, 1'b1);
    check_val("t4_err_rdy", id_rdy, 1'b0);
    check_val("t4_other", {miss_head_flt, len_error}, 2'b00);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("t4_hold", data_flt_timeout, 1'b1);
    end
    retire_keep = 1'b0;
    #1;
    check_val("t4_drop", data_flt_timeout, 1'b1);
    tick();
    check_val("t4_clr", data_flt_timeout, 1'b0);
    check_val("t4_idle_rdy", id_rdy, 1'b1);
    check_val("t4_nwr", wa_q.size(), 0);

    // 5: protocol errors
    wa_q.delete(); wd_q.delete();
    xfer("t5a", 1'b0, 128'hBAD);
    check_val("t5a_miss", miss_head_flt, 1'b1);
    check_val("t5a_other", {data_flt_timeout, len_error}, 2'b00);
    check_val("t5a_rdy", id_rdy, 1'b0);
    tick();
    check_val("t5a_pulse", miss_head_flt, 1'b0);
    xfer("t5b", 1'b1, head_word(10'h040, 8'd0));
    check_val("t5b_len", len_error, 1'b1);
    check_val("t5b_other", {data_flt_timeout, miss_head_flt}, 2'b00);
    tick();
    check_val("t5b_pulse", len_error, 1'b0);
    xfer("t5c_head", 1'b1, head_word(10'h050, 8'd2));
    xfer("t5c_head2", 1'b1, head_word(10'h060, 8'd2));
    check_val("t5c_len", len_error, 1'b1);
    check_val("t5c_rdy", id_rdy, 1'b0);
    tick();
    check_val("t5c_pulse", len_error, 1'b0);
    check_val("t5c_idle", id_rdy, 1'b1);
    check_val("t5_nwr", wa_q.size(), 0);

    // 6: reset mid-packet
    wa_q.delete(); wd_q.delete();
    xfer("t6_head", 1'b1, head_word(10'h200, 8'd4));
    xfer("t6_d0", 1'b0, 128'hF0);
    xfer("t6_d1", 1'b0, 128'hF1);
    id_vld = 1'b1; id_data = 128'hF2;
    rstn = 1'b0;
    #1;
    check_val("t6_rst_wr", sram_wr_en, 1'b0);
    check_val("t6_rst_rdy", id_rdy, 1'b1);
    check_val("t6_rst_len", pkt_len, 8'd0);
    check_val("t6_rst_flags", {data_flt_timeout, miss_head_flt, len_error}, 3'b000);
    id_vld = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    xfer("t6_head2", 1'b1, head_word(10'h010, 8'd1));
    xfer("t6_d", 1'b0, 128'hCAFE);
    check_val("t6_done", pkt_done, 1'b1);
    check_val("t6_len", pkt_len, 8'd1);
    tick();
    check_val("t6_nwr", wa_q.size(), 3);
    check_log("t6_w0", 0, 10'h200, 128'hF0);
    check_log("t6_w1", 1, 10'h201, 128'hF1);
    check_log("t6_w2", 2, 10'h010, 128'hCAFE);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
